// File: rtl/sseg_display_arbiter.sv
// Two-requester arbiter for the 8-digit seven-segment display: round-robin on ties,
// minimum-dwell preemption, registered frame to sseg_driver. Optional blank gap: SSEG_ARB_HANDOVER_BLANK_EN.
module sseg_display_arbiter #(
    parameter int unsigned DWELL        = 16,
    parameter int unsigned BLANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [47:0] frame_a,
    input  logic        req_b,
    input  logic [47:0] frame_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [47:0] frame_out
);

    if (DWELL < 1 || BLANK_CYCLES < 1) begin : g_param_check
        $error("sseg_display_arbiter: DWELL and BLANK_CYCLES must be >= 1");
    end

    localparam int unsigned DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2,
        HANDOVER = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] dwell_cnt;
    logic          last_owner;     // 1: B was granted most recently

`ifdef SSEG_ARB_HANDOVER_BLANK_EN
    localparam int unsigned BW = $clog2(BLANK_CYCLES + 1);
    localparam logic [BW-1:0] BLANK_MAX = BW'(BLANK_CYCLES);
    logic [BW-1:0] blank_cnt;
`endif

    logic take_a, take_b, drop_idle, start_blank;

    always_comb begin
        take_a      = 1'b0;
        take_b      = 1'b0;
        drop_idle   = 1'b0;
        start_blank = 1'b0;
        case (state)
            IDLE: begin
                if (req_a && (!req_b || last_owner)) take_a = 1'b1;
                else if (req_b)                      take_b = 1'b1;
            end
            OWN_A: begin
                if (!req_a && !req_b) drop_idle = 1'b1;
                else if (req_b && (!req_a || dwell_cnt == DWELL_MAX)) begin
`ifdef SSEG_ARB_HANDOVER_BLANK_EN
                    start_blank = 1'b1;
`else
                    take_b = 1'b1;
`endif
                end
            end
            OWN_B: begin
                if (!req_a && !req_b) drop_idle = 1'b1;
                else if (req_a && (!req_b || dwell_cnt == DWELL_MAX)) begin
`ifdef SSEG_ARB_HANDOVER_BLANK_EN
                    start_blank = 1'b1;
`else
                    take_a = 1'b1;
`endif
                end
            end
`ifdef SSEG_ARB_HANDOVER_BLANK_EN
            HANDOVER: begin
                // Pending side is the one that was not last granted; fall back to the previous owner.
                if (blank_cnt == BLANK_MAX) begin
                    if (last_owner ? req_a : req_b) begin
                        take_a = last_owner;
                        take_b = !last_owner;
                    end else if (last_owner ? req_b : req_a) begin
                        take_a = !last_owner;
                        take_b = last_owner;
                    end else begin
                        drop_idle = 1'b1;
                    end
                end
            end
`endif
            default: drop_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            frame_out  <= '0;
            dwell_cnt  <= '0;
            last_owner <= 1'b1;
`ifdef SSEG_ARB_HANDOVER_BLANK_EN
            blank_cnt  <= '0;
`endif
        end else if (take_a) begin
            // dwell_cnt counts owned cycles including the current one
            state      <= OWN_A;
            gnt_a      <= 1'b1;
            gnt_b      <= 1'b0;
            frame_out  <= frame_a;
            dwell_cnt  <= DW'(1);
            last_owner <= 1'b0;
        end else if (take_b) begin
            state      <= OWN_B;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b1;
            frame_out  <= frame_b;
            dwell_cnt  <= DW'(1);
            last_owner <= 1'b1;
        end else if (drop_idle) begin
            state      <= IDLE;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            frame_out  <= '0;
            dwell_cnt  <= '0;
`ifdef SSEG_ARB_HANDOVER_BLANK_EN
        end else if (start_blank) begin
            state      <= HANDOVER;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            frame_out  <= '0;
            dwell_cnt  <= '0;
            blank_cnt  <= BW'(1);
`endif
        end else begin
            case (state)
                OWN_A: begin
                    frame_out <= frame_a;
                    if (dwell_cnt != DWELL_MAX) dwell_cnt <= dwell_cnt + DW'(1);
                end
                OWN_B: begin
                    frame_out <= frame_b;
                    if (dwell_cnt != DWELL_MAX) dwell_cnt <= dwell_cnt + DW'(1);
                end
`ifdef SSEG_ARB_HANDOVER_BLANK_EN
                HANDOVER: blank_cnt <= blank_cnt + BW'(1);
`endif
                default: frame_out <= '0;
            endcase
        end
    end

    // unused when the blank gap is compiled out
    logic unused_start_blank;
    assign unused_start_blank = start_blank;

endmodule
